// File: rtl/regs_wb_arbiter.sv
// Writeback arbiter for the register file's single write port (ALU vs load return),
// with a registered write stage and a per-register pending-write scoreboard.
module regs_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic            i_alu_valid,
    input  logic [AW-1:0]   i_alu_addr,
    input  logic [XLEN-1:0] i_alu_data,
    output logic            o_alu_ready,
    input  logic            i_mem_valid,
    input  logic [AW-1:0]   i_mem_addr,
    input  logic [XLEN-1:0] i_mem_data,
    output logic            o_mem_ready,
    input  logic            i_issue_en,
    input  logic [AW-1:0]   i_issue_rd,
    output logic            o_issue_stall,
    input  logic [AW-1:0]   i_a_addr,
    output logic            o_a_busy,
    input  logic [AW-1:0]   i_b_addr,
    output logic            o_b_busy,
    output logic            o_write_en,
    output logic [AW-1:0]   o_write_addr,
    output logic [XLEN-1:0] o_write_data
);

    // Handshake: a source transfers on valid & ready. Ready is combinational and only
    // asserts with clk_en=1 and rst=0; the requester holds valid/addr/data until ready.
    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    grant_t            r_last_grant;
    grant_t            w_last_grant_next;
    logic              w_gate;
    logic              w_alu_gnt;
    logic              w_mem_gnt;
    logic              w_any_gnt;
    logic [AW-1:0]     w_gnt_addr;
    logic [XLEN-1:0]   w_gnt_data;
    logic              w_issue_set;
    logic [NREGS-1:0]  r_busy;
    logic [NREGS-1:0]  w_busy_next;
    logic              r_write_en;
    logic [AW-1:0]     r_write_addr;
    logic [XLEN-1:0]   r_write_data;

    assign w_gate = clk_en & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= GRANT_ALU;
        end else if (clk_en) begin
            r_last_grant <= w_last_grant_next;
        end
    end

    // On a conflict the source that did not win last time gets the port.
    always_comb begin
        w_alu_gnt         = 1'b0;
        w_mem_gnt         = 1'b0;
        w_last_grant_next = r_last_grant;
        if (w_gate) begin
            if (i_alu_valid && i_mem_valid) begin
                if (r_last_grant == GRANT_ALU) begin
                    w_mem_gnt = 1'b1;
                end else begin
                    w_alu_gnt = 1'b1;
                end
            end else begin
                w_alu_gnt = i_alu_valid;
                w_mem_gnt = i_mem_valid;
            end
            if (w_alu_gnt) begin
                w_last_grant_next = GRANT_ALU;
            end else if (w_mem_gnt) begin
                w_last_grant_next = GRANT_MEM;
            end
        end
    end

    assign w_any_gnt   = w_alu_gnt | w_mem_gnt;
    assign w_gnt_addr  = w_mem_gnt ? i_mem_addr : i_alu_addr;
    assign w_gnt_data  = w_mem_gnt ? i_mem_data : i_alu_data;
    assign o_alu_ready = w_alu_gnt;
    assign o_mem_ready = w_mem_gnt;

    assign o_issue_stall = i_issue_en & r_busy[i_issue_rd];
    assign w_issue_set   = i_issue_en & ~o_issue_stall & (i_issue_rd != '0);
    assign o_a_busy      = r_busy[i_a_addr];
    assign o_b_busy      = r_busy[i_b_addr];

    // Clear is applied first so a same-edge issue to the committing register wins.
    always_comb begin
        w_busy_next = r_busy;
        if (r_write_en) begin
            w_busy_next[r_write_addr] = 1'b0;
        end
        if (w_issue_set) begin
            w_busy_next[i_issue_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy       <= '0;
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
        end else if (clk_en) begin
            r_busy     <= w_busy_next;
            r_write_en <= w_any_gnt & (w_gnt_addr != '0);
            if (w_any_gnt) begin
                r_write_addr <= w_gnt_addr;
                r_write_data <= w_gnt_data;
            end
        end
    end

    assign o_write_en   = r_write_en;
    assign o_write_addr = r_write_addr;
    assign o_write_data = r_write_data;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Bench for regs_wb_arbiter: directed vector table from reset, then randomized
// traffic checked against a transaction-level reference model.
module tb_regs_wb_arbiter;
    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic        issue_stall;
    logic [4:0]  a_addr;
    logic        a_busy;
    logic [4:0]  b_addr;
    logic        b_busy;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [31:0] write_data;

    int checks = 0;
    int failures = 0;

    regs_wb_arbiter #(.XLEN(32), .NREGS(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_alu_valid(alu_valid), .i_alu_addr(alu_addr), .i_alu_data(alu_data), .o_alu_ready(alu_ready),
        .i_mem_valid(mem_valid), .i_mem_addr(mem_addr), .i_mem_data(mem_data), .o_mem_ready(mem_ready),
        .i_issue_en(issue_en), .i_issue_rd(issue_rd), .o_issue_stall(issue_stall),
        .i_a_addr(a_addr), .o_a_busy(a_busy), .i_b_addr(b_addr), .o_b_busy(b_busy),
        .o_write_en(write_en), .o_write_addr(write_addr), .o_write_data(write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, en, av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        ie;
        logic [4:0]  ir, ra;
        logic        e_ardy, e_mrdy, e_stall, e_busy, e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic r, logic en, logic av, logic [4:0] aa, logic [31:0] ad,
                                logic mv, logic [4:0] ma, logic [31:0] md, logic ie, logic [4:0] ir,
                                logic [4:0] ra, logic e_ardy, logic e_mrdy, logic e_stall,
                                logic e_busy, logic e_wen, logic [4:0] e_waddr, logic [31:0] e_wdata);
        vec_t v;
        v.rst = r; v.en = en; v.av = av; v.aa = aa; v.ad = ad;
        v.mv = mv; v.ma = ma; v.md = md; v.ie = ie; v.ir = ir; v.ra = ra;
        v.e_ardy = e_ardy; v.e_mrdy = e_mrdy; v.e_stall = e_stall; v.e_busy = e_busy;
        v.e_wen = e_wen; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    bit [31:0] m_busy;
    bit        m_last_alu;
    bit        m_wen;
    bit [4:0]  m_waddr;
    bit [31:0] m_wdata;

    initial begin
        bit        a_pend, m_pend;
        bit [4:0]  pa_addr, pm_addr;
        bit [31:0] pa_data, pm_data;
        bit        ok, ea, em, es;

        rst = 1; clk_en = 1; alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0; issue_en = 0; issue_rd = 0;
        a_addr = 0; b_addr = 0;
        @(posedge clk); #1;

        //            rst en av aa  ad            mv ma md        ie ir ra  ardy mrdy stl bsy wen waddr wdata
        tbl[0]  = mk(1, 1, 1, 3,  32'h30,       1, 4, 32'h40, 1, 5, 5,  0, 0, 0, 0, 0, 0, 32'h0);
        tbl[1]  = mk(0, 1, 1, 5,  32'hDEADBEEF, 0, 0, 32'h0,  0, 0, 5,  1, 0, 0, 0, 1, 5, 32'hDEADBEEF);
        tbl[2]  = mk(0, 1, 1, 2,  32'h22,       1, 1, 32'h11, 0, 0, 1,  0, 1, 0, 0, 1, 1, 32'h11);
        tbl[3]  = mk(0, 1, 1, 2,  32'h22,       1, 1, 32'h33, 0, 0, 2,  1, 0, 0, 0, 1, 2, 32'h22);
        tbl[4]  = mk(0, 1, 1, 0,  32'h1234,     1, 1, 32'h33, 0, 0, 2,  0, 1, 0, 0, 1, 1, 32'h33);
        tbl[5]  = mk(0, 1, 1, 0,  32'h1234,     0, 0, 32'h0,  1, 0, 0,  1, 0, 0, 0, 0, 0, 32'h0);
        tbl[6]  = mk(0, 1, 0, 0,  32'h0,        0, 0, 32'h0,  1, 7, 7,  0, 0, 0, 0, 0, 0, 32'h0);
        tbl[7]  = mk(0, 1, 0, 0,  32'h0,        1, 7, 32'h77, 1, 7, 7,  0, 1, 1, 1, 1, 7, 32'h77);
        tbl[8]  = mk(0, 1, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0, 7,  0, 0, 0, 1, 0, 0, 32'h0);
        tbl[9]  = mk(0, 1, 0, 0,  32'h0,        1, 7, 32'h78, 0, 0, 7,  0, 1, 0, 0, 1, 7, 32'h78);
        tbl[10] = mk(0, 1, 0, 0,  32'h0,        0, 0, 32'h0,  1, 7, 7,  0, 0, 0, 0, 0, 0, 32'h0);
        tbl[11] = mk(0, 1, 1, 3,  32'hAB,       0, 0, 32'h0,  0, 0, 7,  1, 0, 0, 1, 1, 3, 32'hAB);
        tbl[12] = mk(0, 0, 1, 9,  32'h99,       0, 0, 32'h0,  1, 9, 7,  0, 0, 0, 1, 1, 3, 32'hAB);
        tbl[13] = mk(0, 0, 1, 9,  32'h99,       0, 0, 32'h0,  1, 9, 9,  0, 0, 0, 0, 1, 3, 32'hAB);
        tbl[14] = mk(0, 1, 1, 9,  32'h99,       0, 0, 32'h0,  1, 9, 3,  1, 0, 0, 0, 1, 9, 32'h99);
        tbl[15] = mk(0, 1, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0, 9,  0, 0, 0, 1, 0, 0, 32'h0);
        tbl[16] = mk(1, 1, 1, 4,  32'h55,       0, 0, 32'h0,  0, 0, 7,  0, 0, 0, 1, 0, 0, 32'h0);
        tbl[17] = mk(0, 1, 0, 0,  32'h0,        0, 0, 32'h0,  0, 0, 7,  0, 0, 0, 0, 0, 0, 32'h0);

        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst; clk_en = tbl[i].en;
            alu_valid = tbl[i].av; alu_addr = tbl[i].aa; alu_data = tbl[i].ad;
            mem_valid = tbl[i].mv; mem_addr = tbl[i].ma; mem_data = tbl[i].md;
            issue_en = tbl[i].ie; issue_rd = tbl[i].ir; a_addr = tbl[i].ra; b_addr = tbl[i].ra;
            #1;
            check($sformatf("row%0d alu_ready", i), {31'b0, alu_ready}, {31'b0, tbl[i].e_ardy});
            check($sformatf("row%0d mem_ready", i), {31'b0, mem_ready}, {31'b0, tbl[i].e_mrdy});
            check($sformatf("row%0d issue_stall", i), {31'b0, issue_stall}, {31'b0, tbl[i].e_stall});
            check($sformatf("row%0d a_busy", i), {31'b0, a_busy}, {31'b0, tbl[i].e_busy});
            check($sformatf("row%0d b_busy", i), {31'b0, b_busy}, {31'b0, tbl[i].e_busy});
            @(posedge clk); #1;
            check($sformatf("row%0d write_en", i), {31'b0, write_en}, {31'b0, tbl[i].e_wen});
            if (tbl[i].e_wen) begin
                check($sformatf("row%0d write_addr", i), {27'b0, write_addr}, {27'b0, tbl[i].e_waddr});
                check($sformatf("row%0d write_data", i), write_data, tbl[i].e_wdata);
            end
        end

        // Randomized traffic; model state matches the DUT after the last table row.
        m_busy = '0; m_last_alu = 1; m_wen = 0; m_waddr = 0; m_wdata = 0;
        a_pend = 0; m_pend = 0;
        pa_addr = 0; pm_addr = 0; pa_data = 0; pm_data = 0;
        for (int c = 0; c < 600; c++) begin
            if (!a_pend && $urandom_range(0, 99) < 50) begin
                a_pend = 1; pa_addr = 5'($urandom_range(0, 7)); pa_data = $urandom;
            end
            if (!m_pend && $urandom_range(0, 99) < 50) begin
                m_pend = 1; pm_addr = 5'($urandom_range(0, 7)); pm_data = $urandom;
            end
            rst = ($urandom_range(0, 99) < 2);
            clk_en = ($urandom_range(0, 99) < 80);
            alu_valid = a_pend; alu_addr = pa_addr; alu_data = pa_data;
            mem_valid = m_pend; mem_addr = pm_addr; mem_data = pm_data;
            issue_en = ($urandom_range(0, 99) < 40);
            issue_rd = 5'($urandom_range(0, 7));
            a_addr = 5'($urandom_range(0, 7));
            b_addr = 5'($urandom_range(0, 7));
            #1;
            ok = clk_en && !rst;
            ea = ok && a_pend && (!m_pend || !m_last_alu);
            em = ok && m_pend && (!a_pend || m_last_alu);
            es = issue_en && m_busy[issue_rd];
            check("rnd alu_ready", {31'b0, alu_ready}, {31'b0, ea});
            check("rnd mem_ready", {31'b0, mem_ready}, {31'b0, em});
            check("rnd issue_stall", {31'b0, issue_stall}, {31'b0, es});
            check("rnd a_busy", {31'b0, a_busy}, {31'b0, m_busy[a_addr]});
            check("rnd b_busy", {31'b0, b_busy}, {31'b0, m_busy[b_addr]});
            @(posedge clk); #1;
            if (rst) begin
                m_busy = '0; m_last_alu = 1; m_wen = 0; m_waddr = 0; m_wdata = 0;
                a_pend = 0; m_pend = 0;
            end else if (clk_en) begin
                if (m_wen) m_busy[m_waddr] = 0;
                if (issue_en && !es && issue_rd != 0) m_busy[issue_rd] = 1;
                if (ea) begin
                    m_wen = (pa_addr != 0); m_waddr = pa_addr; m_wdata = pa_data;
                    m_last_alu = 1; a_pend = 0;
                end else if (em) begin
                    m_wen = (pm_addr != 0); m_waddr = pm_addr; m_wdata = pm_data;
                    m_last_alu = 0; m_pend = 0;
                end else begin
                    m_wen = 0;
                end
            end
            check("rnd write_en", {31'b0, write_en}, {31'b0, m_wen});
            if (m_wen) begin
                check("rnd write_addr", {27'b0, write_addr}, {27'b0, m_waddr});
                check("rnd write_data", write_data, m_wdata);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
